// File: rtl/seg7_scan_driver.sv
// 8-digit multiplexed seven-segment driver: shows a captured 32-bit word as hex,
// one digit per prescaler period, with optional leading-zero blanking and frame-synced capture.
module seg7_scan_driver #(
  parameter int SCAN_DIV   = 100000,
  parameter bit LZ_BLANK   = 1'b0,
  parameter bit FRAME_SYNC = 1'b0
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [31:0] i_data,
  input  logic        i_load,
  input  logic [7:0]  i_dp,
  output logic [7:0]  o_seg,
  output logic [7:0]  o_sel,
  output logic        o_frame
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  logic [31:0]   r_shadow;
  logic          w_tick;
  logic          w_boundary;
  logic [7:0]    w_blank;
  logic [3:0]    w_nibble;
  logic [6:0]    w_seg_lo;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  assign w_tick     = (r_presc == LAST);
  assign w_boundary = w_tick && (r_idx == 3'd7);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) r_idx <= r_idx + 3'd1;
    end
  end

  generate
    if (FRAME_SYNC) begin : g_sync
      logic [31:0] r_pending;
      logic        r_pending_valid;
      // A load on the boundary edge refills pending while the older pending is applied.
      always_ff @(posedge clk_in) begin
        if (reset) begin
          r_shadow        <= '0;
          r_pending       <= '0;
          r_pending_valid <= 1'b0;
        end else begin
          if (w_boundary && r_pending_valid) r_shadow <= r_pending;
          if (i_load) begin
            r_pending       <= i_data;
            r_pending_valid <= 1'b1;
          end else if (w_boundary) begin
            r_pending_valid <= 1'b0;
          end
        end
      end
    end else begin : g_direct
      always_ff @(posedge clk_in) begin
        if (reset) r_shadow <= '0;
        else if (i_load) r_shadow <= i_data;
      end
    end
  endgenerate

  assign w_blank[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_blank
      assign w_blank[gi] = LZ_BLANK && (r_shadow[31:4*gi] == '0);
    end
  endgenerate

  assign w_nibble = r_shadow[{r_idx, 2'b00} +: 4];
  assign w_seg_lo = w_blank[r_idx] ? 7'h7F : f_decode(w_nibble);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      o_seg   <= 8'hFF;
      o_sel   <= 8'hFF;
      o_frame <= 1'b0;
    end else begin
      o_sel   <= ~(8'b1 << r_idx);
      o_seg   <= {~i_dp[r_idx], w_seg_lo};
      o_frame <= w_boundary;
    end
  end

endmodule
